div_unit: RTL and testbench

//   Multicycle signed 32-bit divider for DIV. Operands come from the DivSrcA/DivSrcB muxes.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_if.sv | 29 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        ZERO = 2'd3
    } div_state_e;
endpackage

// File: rtl/div_if.sv
// Divider request/result bundle. The optional div_unsigned select exists
// only when DIV_UNSIGNED_EN is defined.
interface div_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
);
    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_UNSIGNED_EN
    logic             div_unsigned;
`endif
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_busy;
    logic             div_done;
    logic             div_zero;

`ifdef DIV_UNSIGNED_EN
    modport master (output div_start, dividend, divisor, div_unsigned,
                    input  hi_out, lo_out, div_busy, div_done, div_zero);
    modport slave  (input  div_start, dividend, divisor, div_unsigned,
                    output hi_out, lo_out, div_busy, div_done, div_zero);
`else
    modport master (output div_start, dividend, divisor,
                    input  hi_out, lo_out, div_busy, div_done, div_zero);
    modport slave  (input  div_start, dividend, divisor,
                    output hi_out, lo_out, div_busy, div_done, div_zero);
`endif
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. The subtraction is done
// one bit wider than the operands so its top bit is the borrow.
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtract; no borrow means the divisor fits and the quotient bit is 1.
    always_comb begin
        shifted  = {rem, dvd_msb};
        diff     = shifted - {1'b0, dvs};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (remainder to HI, quotient to LO), one
// restoring step per clock. Define DIV_UNSIGNED_EN to add the div_unsigned
// select for DIVU-style operation.
module div_unit import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             is_unsigned;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

`ifdef DIV_UNSIGNED_EN
    assign is_unsigned = bus.div_unsigned;
`else
    assign is_unsigned = 1'b0;
`endif

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    always_comb begin
        dividend_neg = ~is_unsigned & bus.dividend[WIDTH-1];
        divisor_neg  = ~is_unsigned & bus.divisor[WIDTH-1];
        dividend_mag = dividend_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        divisor_mag  = divisor_neg  ? (~bus.divisor  + 1'b1) : bus.divisor;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd_msb  (dvd_reg[WIDTH-1]),
        .dvs      (dvs_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Control FSM, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            rem_reg   <= '0;
            quot_reg  <= '0;
            cnt_reg   <= '0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.div_start) begin
                        if (bus.divisor == '0) begin
                            state_reg <= ZERO;
                        end else begin
                            state_reg <= RUN;
                            dvd_reg   <= dividend_mag;
                            dvs_reg   <= divisor_mag;
                            q_neg_reg <= dividend_neg ^ divisor_neg;
                            r_neg_reg <= dividend_neg;
                            rem_reg   <= '0;
                            quot_reg  <= '0;
                            cnt_reg   <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    rem_reg  <= rem_next;
                    dvd_reg  <= {dvd_reg[WIDTH-2:0], 1'b0};
                    quot_reg <= {quot_reg[WIDTH-2:0], q_bit};
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= SIGN;
                    end
                end
                SIGN: begin
                    lo_reg    <= q_neg_reg ? (~quot_reg + 1'b1) : quot_reg;
                    hi_reg    <= r_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                ZERO: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi_out   = hi_reg;
    assign bus.lo_out   = lo_reg;
    assign bus.div_busy = (state_reg == RUN) || (state_reg == SIGN);
    assign bus.div_done = done_reg;
    assign bus.div_zero = (state_reg == ZERO);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operands compared against a plain 64-bit arithmetic reference.
module tb_div_unit;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] hi_exp = '0;
    logic [W-1:0] lo_exp = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncating division on 64-bit integers, remainder follows the dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (uns) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (sb == 0) begin
            q = '0;
            r = '0;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    // Issue one division and check timing, pulses and results.
    // b2b: return in the done cycle so the next start lands there.
    // poke: pulse div_start again during the run (must be ignored).
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit uns, input bit b2b, input bit poke);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int lat;
        int late_events;
        bit stable;
        bit busy_ok;
        model(a, b, uns, q, r);
        stable  = 1'b1;
        busy_ok = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = uns;
`endif
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        lat = 0;
        while (!bus.div_done && !bus.div_zero && lat < 40) begin
            if (bus.hi_out !== hi_exp || bus.lo_out !== lo_exp) stable = 1'b0;
            if (bus.div_busy !== 1'b1) busy_ok = 1'b0;
            bus.div_start = poke && (lat == 5);
            tick();
            lat++;
        end
        bus.div_start = 1'b0;
        if (b == '0) begin
            check({tag, "_zero_lat"}, W'(lat), W'(0));
            check({tag, "_zero_flag"}, W'(bus.div_zero), W'(1));
            check({tag, "_zero_busy"}, W'(bus.div_busy), W'(0));
            check({tag, "_zero_hi"}, bus.hi_out, hi_exp);
            check({tag, "_zero_lo"}, bus.lo_out, lo_exp);
            tick();
            check({tag, "_zero_pulse"}, W'(bus.div_zero), W'(0));
            late_events = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus.div_done || bus.div_zero) late_events++;
                tick();
            end
            check({tag, "_zero_nodone"}, W'(late_events), W'(0));
            check({tag, "_zero_hi_keep"}, bus.hi_out, hi_exp);
            check({tag, "_zero_lo_keep"}, bus.lo_out, lo_exp);
            $display("%s a=%h b=%h div_zero lat=%0d hi=%h lo=%h", tag, a, b, lat, bus.hi_out, bus.lo_out);
        end else begin
            check({tag, "_lat"}, W'(lat), W'(33));
            check({tag, "_done"}, W'(bus.div_done), W'(1));
            check({tag, "_nozero"}, W'(bus.div_zero), W'(0));
            check({tag, "_lo"}, bus.lo_out, q);
            check({tag, "_hi"}, bus.hi_out, r);
            check({tag, "_hold"}, W'(stable), W'(1));
            check({tag, "_busy"}, W'(busy_ok), W'(1));
            check({tag, "_busy_end"}, W'(bus.div_busy), W'(0));
            $display("%s a=%h b=%h uns=%0d lo=%h hi=%h lat=%0d", tag, a, b, uns, bus.lo_out, bus.hi_out, lat);
            hi_exp = r;
            lo_exp = q;
            if (!b2b) begin
                tick();
                check({tag, "_done_pulse"}, W'(bus.div_done), W'(0));
            end
        end
    endtask

    initial begin
        int late_events;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset         = 1'b1;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_hi", bus.hi_out, '0);
        check("rst_lo", bus.lo_out, '0);
        check("rst_busy", W'(bus.div_busy), W'(0));
        check("rst_done", W'(bus.div_done), W'(0));
        check("rst_zero", W'(bus.div_zero), W'(0));

        run_div("pos_7_2", 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        run_div("neg_7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        run_div("pos_7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_div("preset_10_7", 32'd10, 32'd7, 1'b0, 1'b0, 1'b0);
        run_div("div_by_zero", 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Abort a division with reset partway through RUN.
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_exp = '0;
        lo_exp = '0;
        check("abort_hi", bus.hi_out, '0);
        check("abort_lo", bus.lo_out, '0);
        check("abort_busy", W'(bus.div_busy), W'(0));
        check("abort_done", W'(bus.div_done), W'(0));
        check("abort_zero", W'(bus.div_zero), W'(0));
        late_events = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done || bus.div_busy) late_events++;
            tick();
        end
        check("abort_no_done", W'(late_events), W'(0));
        $display("abort reset mid-run hi=%h lo=%h", bus.hi_out, bus.lo_out);

        run_div("restart_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);

        // Randomized back-to-back traffic, with zero and -1 divisors mixed in.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: begin
                    b = W'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = ~b + 1'b1;
                end
                1: b = $urandom;
                2: b = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, 1000));
                default: begin
                    b = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
                end
            endcase
            run_div($sformatf("rand%0d", i), a, b, 1'b0, 1'b1, 1'b0);
        end

`ifdef DIV_UNSIGNED_EN
        run_div("divu_ffff_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
        run_div("div_ffff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_div($sformatf("urand%0d", i), a, b, 1'b1, 1'b1, 1'b0);
        end
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
